// File: rtl/clock_generator_pkg.sv
// Purpose: shared defaults and constants for the programmable clock divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clock_generator_pkg;

    // Width of the half-period counter and of cfg_half.
    localparam int CG_CNT_W        = 16;
    // Half period in reference cycles after reset (period of 10 cycles).
    localparam int CG_DEFAULT_HALF = 5;
    // Width of the rising-edge counter.
    localparam int CG_COUNT_W      = 32;
    // Smallest legal half period; a requested 0 is promoted to this.
    localparam int CG_MIN_HALF     = 1;

endpackage

// File: rtl/half_period_counter.sv
// Purpose: counts reference cycles within one half period and flags the terminal count.
// Latency: wrap is combinational from the registered count; count updates every clk.
// Backpressure: none; run low parks the count at 0.
//
// Ports:
//   clk, reset - reference clock, synchronous active-high reset
//   run        - count while high, hold at 0 while low
//   half       - active half period (always >= 1)
//   wrap       - high in the cycle where cnt == half-1 while running
module half_period_counter
    import clock_generator_pkg::*;
#(
    parameter int CNT_W = CG_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [CNT_W-1:0] half,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt;

    assign wrap = run && (cnt == (half - CNT_W'(CG_MIN_HALF)));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (!run || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/clock_generator.sv
// Purpose: programmable 50% duty-cycle clock divider with edge strobes and a rise counter.
// Latency: all outputs registered; a new half period takes effect at the next 1->0 boundary.
// Backpressure: cfg_ready low while one configuration is pending; further offers wait.
//
// Ports:
//   clk, reset            - reference clock, synchronous active-high reset
//   enable                - run/stop request; a high phase in progress always completes
//   cfg_valid/cfg_ready   - handshake for a new half period on cfg_half (0 treated as 1)
//   clock                 - divided clock
//   rise_tick, fall_tick  - one-cycle strobes in the first cycle of each high / low phase
//   cycle_count           - number of clock rising edges since reset, wraps
module clock_generator
    import clock_generator_pkg::*;
#(
    parameter int CNT_W        = CG_CNT_W,
    parameter int DEFAULT_HALF = CG_DEFAULT_HALF,
    parameter int COUNT_W      = CG_COUNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               cfg_valid,
    input  logic [CNT_W-1:0]   cfg_half,
    output logic               cfg_ready,
    output logic               clock,
    output logic               rise_tick,
    output logic               fall_tick,
    output logic [COUNT_W-1:0] cycle_count
);

    localparam logic [CNT_W-1:0] RESET_HALF =
        (DEFAULT_HALF < CG_MIN_HALF) ? CNT_W'(CG_MIN_HALF) : CNT_W'(DEFAULT_HALF);

    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] pend_half;
    logic             pend_vld;
    logic [CNT_W-1:0] cfg_half_clamped;
    logic             run;
    logic             wrap;
    logic             cfg_fire;
    logic             cfg_apply;

    // A high phase always runs to completion, so the divider keeps going
    // while clock is high even after enable drops.
    assign run = enable | clock;

    assign cfg_ready        = ~pend_vld;
    assign cfg_fire         = cfg_valid & ~pend_vld;
    assign cfg_half_clamped = (cfg_half == '0) ? CNT_W'(CG_MIN_HALF) : cfg_half;

    // Swap the ratio only where the count restarts from 0: on the 1->0
    // toggle, or whenever the divider is parked.
    assign cfg_apply = pend_vld & ((wrap & clock) | ~run);

    half_period_counter #(
        .CNT_W (CNT_W)
    ) u_half_period_counter (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .half  (half),
        .wrap  (wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            clock       <= 1'b0;
            rise_tick   <= 1'b0;
            fall_tick   <= 1'b0;
            cycle_count <= '0;
            half        <= RESET_HALF;
            pend_half   <= RESET_HALF;
            pend_vld    <= 1'b0;
        end else begin
            rise_tick <= wrap & ~clock;
            fall_tick <= wrap & clock;
            if (wrap) begin
                clock <= ~clock;
            end
            if (wrap && !clock) begin
                cycle_count <= cycle_count + COUNT_W'(1);
            end
            // Apply and capture are exclusive: capture needs the slot empty,
            // apply needs it full.
            if (cfg_apply) begin
                half     <= pend_half;
                pend_vld <= 1'b0;
            end else if (cfg_fire) begin
                pend_half <= cfg_half_clamped;
                pend_vld  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clock_generator.sv
// Purpose: self-checking bench for clock_generator against a timestamp-based reference model.
// Latency: every output is compared once per reference cycle, on the falling clk edge.
// Backpressure: the model tracks the single pending configuration slot independently.
module tb_clock_generator;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        cfg_valid;
    logic [15:0] cfg_half;
    logic        cfg_ready;
    logic        clock;
    logic        rise_tick;
    logic        fall_tick;
    logic [31:0] cycle_count;

    // Second instance with a 4-bit counter and half period 1 for wrap checks.
    logic        en_w;
    logic        w_cfg_ready;
    logic        w_clock;
    logic        w_rise;
    logic        w_fall;
    logic [3:0]  w_count;

    always #5 clk = ~clk;

    clock_generator u_dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_half    (cfg_half),
        .cfg_ready   (cfg_ready),
        .clock       (clock),
        .rise_tick   (rise_tick),
        .fall_tick   (fall_tick),
        .cycle_count (cycle_count)
    );

    clock_generator #(
        .COUNT_W      (4),
        .DEFAULT_HALF (1)
    ) u_wrap (
        .clk         (clk),
        .reset       (reset),
        .enable      (en_w),
        .cfg_valid   (1'b0),
        .cfg_half    (16'd0),
        .cfg_ready   (w_cfg_ready),
        .clock       (w_clock),
        .rise_tick   (w_rise),
        .fall_tick   (w_fall),
        .cycle_count (w_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each phase is described by the clk edge index at
    // which the next toggle is due, computed from the half period in force.
    int          t;
    logic        m_clock, m_rise, m_fall, m_pend;
    int          m_half, m_pend_half, m_dead;
    bit          m_run;
    logic [31:0] m_count;
    logic        mw_clock, mw_rise, mw_fall;
    logic [3:0]  mw_count;
    bit          saw_wrap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic en, input logic cv, input int ch);
        bit active, tog, apply, capture;
        if (r) begin
            m_clock = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
            m_half = 5; m_pend = 1'b0; m_count = 0; m_run = 1'b0;
            mw_clock = 1'b0; mw_rise = 1'b0; mw_fall = 1'b0; mw_count = 0;
        end else begin
            active = en || m_clock;
            tog = 1'b0;
            if (!active) begin
                m_run = 1'b0;
            end else begin
                if (!m_run) begin
                    m_run  = 1'b1;
                    m_dead = t + m_half - 1;
                end
                tog = (t == m_dead);
            end
            apply   = m_pend && ((tog && m_clock) || !active);
            capture = cv && !m_pend;
            m_rise  = tog && !m_clock;
            m_fall  = tog && m_clock;
            if (apply) begin
                m_half = m_pend_half;
                m_pend = 1'b0;
            end
            if (capture) begin
                m_pend      = 1'b1;
                m_pend_half = (ch == 0) ? 1 : ch;
            end
            if (tog) begin
                m_clock = !m_clock;
                m_dead  = t + m_half;
                if (m_rise) m_count = m_count + 1;
            end
            // Half period 1: the wrap instance toggles on every active edge.
            if (en_w || mw_clock) begin
                mw_clock = !mw_clock;
                mw_rise  = mw_clock;
                mw_fall  = !mw_clock;
                if (mw_clock) mw_count = mw_count + 4'd1;
            end else begin
                mw_rise = 1'b0;
                mw_fall = 1'b0;
            end
        end
        t++;
    endtask

    task automatic step(input logic r, input logic en, input logic cv, input int ch);
        logic [3:0] w_prev;
        w_prev    = w_count;
        reset     = r;
        enable    = en;
        cfg_valid = cv;
        cfg_half  = ch[15:0];
        @(posedge clk);
        model_edge(r, en, cv, ch);
        @(negedge clk);
        check("clock", clock, m_clock);
        check("rise_tick", rise_tick, m_rise);
        check("fall_tick", fall_tick, m_fall);
        check("cycle_count", cycle_count, m_count);
        check("cfg_ready", cfg_ready, !m_pend);
        check("w_clock", w_clock, mw_clock);
        check("w_rise", w_rise, mw_rise);
        check("w_fall", w_fall, mw_fall);
        check("w_count", w_count, mw_count);
        check("w_cfg_ready", w_cfg_ready, 1);
        if (!r && w_prev == 4'd15 && w_count == 4'd0) saw_wrap = 1'b1;
    endtask

    task automatic wait_rise(input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step(0, enable, 0, 0);
            if (rise_tick) begin
                found = 1'b1;
                break;
            end
        end
        check("rise_seen", found, 1);
    endtask

    // Number of consecutive samples at the current clock level, including
    // the current one; returns positioned on the first sample of the next level.
    task automatic phase_len(output int n);
        logic cur;
        n   = 1;
        cur = clock;
        for (int i = 0; i < 64; i++) begin
            step(0, enable, 0, 0);
            if (clock !== cur) break;
            n++;
        end
    endtask

    initial begin
        int   rises, h, l;
        logic prev;
        logic [31:0] saved;

        reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_half = '0; en_w = 1'b1;
        t = 0; saw_wrap = 1'b0;
        m_clock = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_pend = 1'b0;
        m_half = 5; m_pend_half = 5; m_dead = 0; m_run = 1'b0; m_count = 0;
        mw_clock = 1'b0; mw_rise = 1'b0; mw_fall = 1'b0; mw_count = 0;

        // Reset state
        repeat (3) step(1, 0, 0, 0);
        check("rst_clock", clock, 0);
        check("rst_ready", cfg_ready, 1);
        check("rst_count", cycle_count, 0);

        // Default ratio: first rise after 5 edges, period 10
        rises = 0;
        for (int i = 1; i <= 100; i++) begin
            step(0, 1, 0, 0);
            if (i == 4) check("first_rise_early", clock, 0);
            if (i == 5) check("first_rise", clock, 1);
            if (rise_tick) rises++;
        end
        check("count_after_100", cycle_count, 10);
        check("rises_after_100", rises, 10);

        // Reconfigure to 3 during a high phase
        wait_rise(30);
        step(0, 1, 1, 3);
        check("cfg_ready_drop", cfg_ready, 0);
        phase_len(h);
        check("hi_kept_5", h + 1, 5);
        check("fall_at_boundary", fall_tick, 1);
        check("cfg_ready_back", cfg_ready, 1);
        phase_len(l);
        check("lo_new_3", l, 3);
        phase_len(h);
        check("hi_new_3", h, 3);

        // Zero half period: toggle every cycle, strobes alternate
        step(0, 1, 1, 0);
        repeat (12) step(0, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            prev = clock;
            step(0, 1, 0, 0);
            check("zero_toggle", clock, !prev);
            check("zero_strobe", rise_tick ^ fall_tick, 1);
        end

        // Back to 5, then stop two cycles into a high phase
        step(0, 1, 1, 5);
        repeat (4) step(0, 1, 0, 0);
        check("cfg5_applied", cfg_ready, 1);
        wait_rise(30);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        phase_len(h);
        check("stop_hi_more", h, 3);
        check("stop_fall_tick", fall_tick, 1);
        saved = m_count;
        rises = 0;
        repeat (10) begin
            step(0, 0, 0, 0);
            if (rise_tick) rises++;
        end
        check("stop_held_low", clock, 0);
        check("stop_no_rise", rises, 0);
        check("stop_count_frozen", cycle_count, saved);

        // Restart: first rise half cycles after enable
        step(0, 1, 0, 0);
        phase_len(l);
        check("restart_low", l, 4);

        // Reset during a high phase with a pending configuration
        step(0, 1, 1, 7);
        check("pend_before_reset", cfg_ready, 0);
        step(1, 1, 0, 0);
        check("reset_mid_clock", clock, 0);
        check("reset_mid_ready", cfg_ready, 1);
        check("reset_mid_count", cycle_count, 0);
        step(0, 1, 0, 0);
        phase_len(l);
        check("post_reset_low", l, 4);
        phase_len(h);
        check("post_reset_hi", h, 5);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                 int'($urandom_range(0, 6)));
        end

        check("w_wrap_seen", saw_wrap, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_generator.md
# clock_generator

Synthesizable programmable clock divider that derives the processor's system clock from a faster reference clock. It produces a 50 % duty-cycle divided clock plus single-cycle edge strobes and a rising-edge counter. It sits at the top of the pipeline-processor hierarchy and feeds the instruction memory, register file and pipeline registers. Divide ratio changes are applied only at period boundaries, so the output never has runt pulses.

## Interface
Parameters:
- CNT_W, 16: width of the half-period counter and of `cfg_half`.
- DEFAULT_HALF, 5: half period in reference cycles after reset. With this default, the output period is 10 reference cycles.
- COUNT_W, 32: width of `cycle_count`.

Ports:
- `clk`, in, 1: reference clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset. One clock, `clk`; reset polarity and synchronicity are fixed as stated.
- `enable`, in, 1: run/stop request for the divided clock.
- `cfg_valid`, in, 1: new half-period offered.
- `cfg_half`, in, CNT_W: requested half period in reference cycles.
- `cfg_ready`, out, 1: high when no configuration is pending.
- `clock`, out, 1: divided clock, registered output.
- `rise_tick`, out, 1: one-cycle strobe, high in the first `clk` cycle in which `clock` is 1.
- `fall_tick`, out, 1: one-cycle strobe, high in the first `clk` cycle in which `clock` is 0 after a high phase.
- `cycle_count`, out, COUNT_W: number of `clock` rising edges since reset.

## Operation
- **Active register:** `half` is the active half period. A `cfg_half` value of 0 is stored as 1.
- **Counter:** `cnt` runs 0 .. `half`-1 while running. When `cnt`==`half`-1, `clock` toggles and `cnt` returns to 0; otherwise `cnt` increments.
- **Strobes:** `rise_tick` and `fall_tick` are registered together with `clock`. They are never high simultaneously and never high while stopped.
- **Cycle counter:** `cycle_count` increments on every 0->1 toggle. It wraps from all-ones to 0.
- **Configuration handshake:**
  - A transfer occurs when `cfg_valid` and `cfg_ready` are both high. The value goes into a pending register and `cfg_ready` drops.
  - The pending value becomes `half` at the next period boundary, i.e. the cycle in which `clock` toggles 1->0, or on the next cycle if stopped.
  - `cfg_ready` returns high in the cycle after the value is applied.
- **Stopping:**
  - Deasserting `enable` while `clock` is low stops immediately: `cnt` is held at 0 and `clock` stays low.
  - Deasserting `enable` while `clock` is high completes the high phase. The 1->0 toggle and `fall_tick` still occur, then the block stops.
- **Restarting:** `enable` rising while stopped restarts counting from `cnt`=0. The first rise then occurs `half` cycles later.
- **Reset values:** `clock`=0, `cnt`=0, `half`=DEFAULT_HALF, pending cleared, `cfg_ready`=1, `rise_tick`=0, `fall_tick`=0, `cycle_count`=0.
- **Simultaneous events:** reset overrides everything. An offered configuration and a period boundary in the same cycle: the new value is captured, not applied, and is applied at the next boundary.

## Timing
- With `enable` high from reset release, `clock` first reads 1 after the `half`-th rising edge of `clk` following the release cycle.
- From then on, `clock` alternates every `half` `clk` cycles: period 2·`half`, duty cycle exactly 50 %.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted mid-period forces the reset values on the next `clk` edge. Any partial period is discarded.

## Structure
- Package `clock_generator_pkg` holds:
  - the DEFAULT_HALF, CNT_W and COUNT_W defaults;
  - the helper constant for the minimum half period (1).
- One natural sub-module, `half_period_counter`:
  - contains `cnt` and the terminal-count compare, exposing a `wrap` pulse;
  - the top level owns the `clock` flop, strobes, configuration handshake and `cycle_count`.

## Test plan
- **Default ratio:** reset 3 cycles, release, `enable`=1 -> `clock` rises after 5 `clk` cycles, period 10. After 100 `clk` cycles, `cycle_count`=10. Exactly one `rise_tick` per period.
- **Reconfigure mid-high:** offer `cfg_half`=3 while `clock` is high -> `cfg_ready` drops. The current high phase stays 5 cycles, subsequent periods are 6, and `cfg_ready` returns after the boundary.
- **Zero half period:** `cfg_half`=0 -> `clock` toggles every `clk` cycle (period 2). Strobes alternate.
- **Stop mid-high:** `enable` drops 2 cycles into a high phase -> `clock` stays high 3 more cycles, falls with `fall_tick`, then holds low. `cycle_count` is frozen.
- **Reset mid-operation:** reset during a high phase with a pending config -> next cycle `clock`=0, `cfg_ready`=1, `cycle_count`=0, and `half` reverts to 5.
- **Counter wrap:** COUNT_W=4, run 16 rising edges -> `cycle_count` goes 15 -> 0.
